// File: rtl/task_fifo_mq.sv
// Per-tree task FIFOs steered by TreeId, drained round-robin into a registered valid/ready stage.
// Push-to-valid latency is two edges; output holds and no queue pops while out_valid && !out_ready.
module task_fifo_mq #(
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int QUEUE_DEPTH   = 8,
  parameter int QUEUE_WIDTH   = $clog2(QUEUE_DEPTH),
  parameter int AFULL_THRESH  = QUEUE_DEPTH - 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [PTW+TREE_NUM_BITS:0]           buf_in,
  input  logic                                 flush_en,
  input  logic [TREE_NUM_BITS-1:0]             flush_id,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [PTW+TREE_NUM_BITS:0]           buf_out,
  output logic [TREE_NUM-1:0]                  buf_empty,
  output logic [TREE_NUM-1:0]                  buf_full,
  output logic [TREE_NUM-1:0]                  buf_afull,
  output logic [TREE_NUM*(QUEUE_WIDTH+1)-1:0]  fifo_counter,
  output logic [15:0]                          drop_cnt
);

  localparam int W  = PTW + TREE_NUM_BITS + 1;
  localparam int CW = QUEUE_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
  localparam logic [TREE_NUM_BITS-1:0] LAST_ID = TREE_NUM_BITS'(TREE_NUM - 1);

  logic [W-1:0]             r_mem [TREE_NUM][QUEUE_DEPTH];
  logic [QUEUE_WIDTH-1:0]   r_wr_ptr [TREE_NUM];
  logic [QUEUE_WIDTH-1:0]   r_rd_ptr [TREE_NUM];
  logic [CW-1:0]            r_cnt [TREE_NUM];
  logic [TREE_NUM_BITS-1:0] r_rr_ptr;
  logic                     r_out_valid;
  logic [W-1:0]             r_buf_out;
  logic [15:0]              r_drop_cnt;

  logic [TREE_NUM_BITS-1:0] w_push_id;
  logic [TREE_NUM-1:0]      w_flush_hit;
  logic [TREE_NUM-1:0]      w_push_req;
  logic [TREE_NUM-1:0]      w_push_acc;
  logic [TREE_NUM-1:0]      w_full;
  logic [TREE_NUM-1:0]      w_elig;
  logic [TREE_NUM-1:0]      w_pop_vec;
  logic                     w_load;
  logic                     w_pop;
  logic                     w_gnt_vld;
  logic [TREE_NUM_BITS-1:0] w_gnt_id;
  logic                     w_drop;
  int                       w_dist;
  int                       w_best;

  assign w_push_id = buf_in[PTW +: TREE_NUM_BITS];
  assign w_load    = !r_out_valid || out_ready;
  assign w_pop     = w_load && w_gnt_vld;

  always_comb begin
    w_flush_hit = '0;
    w_push_req  = '0;
    w_full      = '0;
    w_elig      = '0;
    for (int i = 0; i < TREE_NUM; i++) begin
      w_flush_hit[i] = flush_en && (flush_id == TREE_NUM_BITS'(i));
      w_push_req[i]  = wr_en && (w_push_id == TREE_NUM_BITS'(i));
      w_full[i]      = (r_cnt[i] == DEPTH_C);
      // A queue being flushed this cycle must not be granted.
      w_elig[i]      = (r_cnt[i] != '0) && !w_flush_hit[i];
    end
  end

  // Grant the eligible queue at the smallest circular distance from r_rr_ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_best    = TREE_NUM;
    w_dist    = 0;
    for (int i = 0; i < TREE_NUM; i++) begin
      w_dist = (i + TREE_NUM - int'(r_rr_ptr)) % TREE_NUM;
      if (w_elig[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_id  = TREE_NUM_BITS'(i);
        w_gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_pop_vec  = '0;
    w_push_acc = '0;
    for (int i = 0; i < TREE_NUM; i++) begin
      w_pop_vec[i]  = w_pop && (w_gnt_id == TREE_NUM_BITS'(i));
      w_push_acc[i] = w_push_req[i] && !w_flush_hit[i] && (!w_full[i] || w_pop_vec[i]);
    end
    // Out-of-range TreeId hits no queue; flush discards are not drops.
    w_drop = wr_en && ((w_push_req == '0) ||
                       ((w_push_req & w_full & ~w_pop_vec & ~w_flush_hit) != '0));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < TREE_NUM; i++) begin
      if (w_push_acc[i]) r_mem[i][r_wr_ptr[i]] <= buf_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TREE_NUM; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < TREE_NUM; i++) begin
        if (w_flush_hit[i]) begin
          r_wr_ptr[i] <= '0;
          r_rd_ptr[i] <= '0;
          r_cnt[i]    <= '0;
        end else begin
          if (w_push_acc[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
          if (w_pop_vec[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
          r_cnt[i] <= r_cnt[i] + CW'(w_push_acc[i]) - CW'(w_pop_vec[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_buf_out   <= '0;
      r_rr_ptr    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_load) begin
        if (w_gnt_vld) begin
          r_out_valid <= 1'b1;
          r_buf_out   <= r_mem[w_gnt_id][r_rd_ptr[w_gnt_id]];
          r_rr_ptr    <= (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  always_comb begin
    buf_empty    = '0;
    buf_full     = '0;
    buf_afull    = '0;
    fifo_counter = '0;
    for (int i = 0; i < TREE_NUM; i++) begin
      buf_empty[i]               = (r_cnt[i] == '0);
      buf_full[i]                = w_full[i];
      buf_afull[i]               = (r_cnt[i] >= AFULL_C);
      fifo_counter[i*CW +: CW]   = r_cnt[i];
    end
  end

  assign out_valid = r_out_valid;
  assign buf_out   = r_buf_out;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_task_fifo_mq.sv
// Bench for task_fifo_mq: directed vector table, hand sequences and random traffic against a queue-based model.
module tb_task_fifo_mq;
  localparam int PTW = 16;
  localparam int TN  = 4;
  localparam int TB  = 2;
  localparam int QD  = 8;
  localparam int W   = PTW + TB + 1;

  typedef logic [W-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  word_t            buf_in;
  logic             flush_en;
  logic [TB-1:0]    flush_id;
  logic             out_valid;
  logic             out_ready;
  word_t            buf_out;
  logic [TN-1:0]    buf_empty;
  logic [TN-1:0]    buf_full;
  logic [TN-1:0]    buf_afull;
  logic [TN*4-1:0]  fifo_counter;
  logic [15:0]      drop_cnt;

  task_fifo_mq dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in),
    .flush_en(flush_en), .flush_id(flush_id),
    .out_valid(out_valid), .out_ready(out_ready), .buf_out(buf_out),
    .buf_empty(buf_empty), .buf_full(buf_full), .buf_afull(buf_afull),
    .fifo_counter(fifo_counter), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: one queue per tree, an output register and a round-robin pointer.
  word_t mq [TN][$];
  int    m_rr;
  logic  m_ov;
  word_t m_out;
  int    m_drop;

  function automatic word_t mk(input logic op, input logic [TB-1:0] t, input logic [15:0] d);
    return {op, t, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TN; i++) mq[i].delete();
    m_rr = 0; m_ov = 1'b0; m_out = '0; m_drop = 0;
  endtask

  task automatic model_step(input logic wr, input word_t w, input logic fl, input int fid, input logic rdy);
    int g;
    int t;
    g = -1;
    for (int k = 0; k < TN; k++) begin
      int i;
      i = (m_rr + k) % TN;
      if (g < 0 && mq[i].size() > 0 && !(fl && fid == i)) g = i;
    end
    if (!m_ov || rdy) begin
      if (g >= 0) begin
        m_out = mq[g].pop_front();
        m_ov  = 1'b1;
        m_rr  = (g + 1) % TN;
      end else begin
        m_ov = 1'b0;
      end
    end
    if (wr) begin
      t = int'(w[PTW +: TB]);
      if (t >= TN) m_drop++;
      else if (fl && fid == t) begin end
      else if (mq[t].size() < QD) mq[t].push_back(w);
      else m_drop++;
      if (m_drop > 65535) m_drop = 65535;
    end
    if (fl) mq[fid].delete();
  endtask

  task automatic compare_all();
    logic [TN*4-1:0] ec;
    logic [TN-1:0]   ee, ef, ea;
    ec = '0; ee = '0; ef = '0; ea = '0;
    for (int i = 0; i < TN; i++) begin
      ec[i*4 +: 4] = 4'(mq[i].size());
      ee[i] = (mq[i].size() == 0);
      ef[i] = (mq[i].size() == QD);
      ea[i] = (mq[i].size() >= QD - 2);
    end
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("buf_out", 64'(buf_out), 64'(m_out));
    check("fifo_counter", 64'(fifo_counter), 64'(ec));
    check("buf_empty", 64'(buf_empty), 64'(ee));
    check("buf_full", 64'(buf_full), 64'(ef));
    check("buf_afull", 64'(buf_afull), 64'(ea));
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
  endtask

  task automatic step(input logic wr, input word_t w, input logic fl, input logic [TB-1:0] fid, input logic rdy);
    wr_en = wr; buf_in = w; flush_en = fl; flush_id = fid; out_ready = rdy;
    @(posedge clk);
    model_step(wr, w, fl, int'(fid), rdy);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic  wr;
    word_t w;
    logic  rdy;
    logic  exp_ov;
    word_t exp_out;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  tbl [15];
    word_t held;
    int    pct;

    tbl[0]  = '{1'b1, mk(1, 2, 16'hABCD), 1'b1, 1'b0, word_t'(0)};
    tbl[1]  = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(1, 2, 16'hABCD)};
    tbl[2]  = '{1'b0, word_t'(0),         1'b1, 1'b0, mk(1, 2, 16'hABCD)};
    tbl[3]  = '{1'b1, mk(0, 0, 16'h0001), 1'b0, 1'b0, mk(1, 2, 16'hABCD)};
    tbl[4]  = '{1'b1, mk(0, 0, 16'h0002), 1'b0, 1'b1, mk(0, 0, 16'h0001)};
    tbl[5]  = '{1'b1, mk(0, 1, 16'h0011), 1'b0, 1'b1, mk(0, 0, 16'h0001)};
    tbl[6]  = '{1'b1, mk(0, 1, 16'h0012), 1'b0, 1'b1, mk(0, 0, 16'h0001)};
    tbl[7]  = '{1'b1, mk(0, 3, 16'h0031), 1'b0, 1'b1, mk(0, 0, 16'h0001)};
    tbl[8]  = '{1'b1, mk(0, 3, 16'h0032), 1'b0, 1'b1, mk(0, 0, 16'h0001)};
    tbl[9]  = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(0, 1, 16'h0011)};
    tbl[10] = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(0, 3, 16'h0031)};
    tbl[11] = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(0, 0, 16'h0002)};
    tbl[12] = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(0, 1, 16'h0012)};
    tbl[13] = '{1'b0, word_t'(0),         1'b1, 1'b1, mk(0, 3, 16'h0032)};
    tbl[14] = '{1'b0, word_t'(0),         1'b1, 1'b0, mk(0, 3, 16'h0032)};

    rst = 1'b1; wr_en = 1'b0; buf_in = '0; flush_en = 1'b0; flush_id = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // Single push latency, then round-robin order 0,1,3,0,1,3.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].wr, tbl[i].w, 1'b0, '0, tbl[i].rdy);
      check($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      check($sformatf("tbl%0d_out", i), 64'(buf_out), 64'(tbl[i].exp_out));
    end

    // Fill tree 1 with the consumer stalled; the first word parks in the output register.
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, mk(0, 1, 16'h0100 + 16'(k)), 1'b0, '0, 1'b0);
      if (k == 6) check("fill_afull_at5", 64'(buf_afull[1]), 64'd0);
      if (k == 7) begin
        check("fill_afull_at6", 64'(buf_afull[1]), 64'd1);
        check("fill_full_at6", 64'(buf_full[1]), 64'd0);
      end
      if (k == 9) check("fill_full_at8", 64'(buf_full[1]), 64'd1);
    end
    check("fill_cnt", 64'(fifo_counter[4 +: 4]), 64'd8);
    check("fill_drop", 64'(drop_cnt), 64'd1);
    check("fill_out", 64'(buf_out), 64'(mk(0, 1, 16'h0101)));

    // Backpressure toggling with a push to the full queue on each accepted cycle.
    held = mk(0, 1, 16'h0101);
    for (int r = 0; r < 4; r++) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      check("bp_hold", 64'(buf_out), 64'(held));
      step(1'b1, mk(0, 1, 16'h01A0 + 16'(r)), 1'b0, '0, 1'b1);
      held = mk(0, 1, 16'h0102 + 16'(r));
      check("bp_out", 64'(buf_out), 64'(held));
      check("bp_cnt", 64'(fifo_counter[4 +: 4]), 64'd8);
      check("bp_drop", 64'(drop_cnt), 64'd1);
    end
    repeat (12) step(1'b0, '0, 1'b0, '0, 1'b1);
    check("drain_ov", 64'(out_valid), 64'd0);
    check("drain_empty", 64'(buf_empty), 64'hF);

    // Flush tree 2 while pushing to it.
    for (int k = 1; k <= 6; k++) step(1'b1, mk(1, 2, 16'h0200 + 16'(k)), 1'b0, '0, 1'b0);
    check("flush_pre_cnt", 64'(fifo_counter[8 +: 4]), 64'd5);
    step(1'b1, mk(1, 2, 16'h02FF), 1'b1, 2'd2, 1'b1);
    check("flush_cnt", 64'(fifo_counter[8 +: 4]), 64'd0);
    check("flush_drop", 64'(drop_cnt), 64'd1);
    check("flush_ov", 64'(out_valid), 64'd0);
    repeat (3) begin
      step(1'b0, '0, 1'b0, '0, 1'b1);
      check("flush_after_ov", 64'(out_valid), 64'd0);
    end

    // Random traffic with varying consumer duty cycle.
    pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) pct = (n / 200 % 3 == 0) ? 20 : ((n / 200 % 3 == 1) ? 50 : 95);
      step(($urandom % 4) != 0, word_t'($urandom), ($urandom % 20) == 0,
           TB'($urandom % TN), ($urandom % 100) < 32'(pct));
    end

    // Asynchronous reset mid-stream with three entries queued.
    repeat (40) step(1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, mk(0, 0, 16'h0E00 + 16'(k)), 1'b0, '0, 1'b0);
    check("rst_pre_cnt", 64'(fifo_counter[0 +: 4]), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_empty", 64'(buf_empty), 64'hF);
    check("rst_cnt", 64'(fifo_counter), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, mk(1, 3, 16'h0BEE), 1'b0, '0, 1'b1);
    check("post_rst_ov1", 64'(out_valid), 64'd0);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("post_rst_ov2", 64'(out_valid), 64'd1);
    check("post_rst_out", 64'(buf_out), 64'(mk(1, 3, 16'h0BEE)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
